// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: the write-back stage always wins and a held debug
// request is granted in the first free slot. A stall is raised if the request starves.
module reg_write_arbiter #(
  parameter int LEN          = 32,
  parameter int NB_ADDR      = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int NB_CNT       = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_wb_RegWrite,
  input  logic [NB_ADDR-1:0] i_wb_write_register,
  input  logic [LEN-1:0]     i_wb_write_data,
  input  logic               i_dbg_req,
  input  logic [NB_ADDR-1:0] i_dbg_write_register,
  input  logic [LEN-1:0]     i_dbg_write_data,
  output logic               o_rf_we,
  output logic [NB_ADDR-1:0] o_rf_addr,
  output logic [LEN-1:0]     o_rf_data,
  output logic               o_dbg_ack,
  output logic               o_pipe_stall,
  output logic [NB_CNT-1:0]  o_dbg_write_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          wb_sel;
  logic          slot_free;
  logic          grant;

  // A write-back to register 0 is a no-op, so it leaves the slot free for debug.
  assign wb_sel    = i_wb_RegWrite && (i_wb_write_register != '0);
  assign slot_free = !wb_sel;
  assign grant     = i_dbg_req && slot_free && ((state == IDLE) || (state == WAIT));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state             <= IDLE;
      starve_cnt        <= '0;
      o_rf_we           <= 1'b0;
      o_rf_addr         <= '0;
      o_rf_data         <= '0;
      o_dbg_ack         <= 1'b0;
      o_pipe_stall      <= 1'b0;
      o_dbg_write_count <= '0;
    end else begin
      o_dbg_ack <= grant;
      if (grant) o_dbg_write_count <= o_dbg_write_count + 1'b1;

      if (wb_sel) begin
        o_rf_we   <= 1'b1;
        o_rf_addr <= i_wb_write_register;
        o_rf_data <= i_wb_write_data;
      end else if (grant && (i_dbg_write_register != '0)) begin
        o_rf_we   <= 1'b1;
        o_rf_addr <= i_dbg_write_register;
        o_rf_data <= i_dbg_write_data;
      end else begin
        o_rf_we   <= 1'b0;
      end

      case (state)
        IDLE: begin
          starve_cnt   <= '0;
          o_pipe_stall <= 1'b0;
          if (i_dbg_req) state <= grant ? RELEASE : WAIT;
        end
        WAIT: begin
          if (!i_dbg_req || grant) begin
            state        <= i_dbg_req ? RELEASE : IDLE;
            starve_cnt   <= '0;
            o_pipe_stall <= 1'b0;
          end else begin
            // Stall is driven from the saturated count, one cycle behind it.
            starve_cnt   <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
            o_pipe_stall <= (starve_cnt == LIMIT);
          end
        end
        RELEASE: begin
          starve_cnt   <= '0;
          o_pipe_stall <= 1'b0;
          if (!i_dbg_req) state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          starve_cnt   <= '0;
          o_pipe_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: stimulus pushes expected writes/acks,
// a negedge monitor pops and compares whenever the DUT shows a write or an ack.
module tb_reg_write_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_wb_RegWrite;
  logic [4:0]  i_wb_write_register;
  logic [31:0] i_wb_write_data;
  logic        i_dbg_req;
  logic [4:0]  i_dbg_write_register;
  logic [31:0] i_dbg_write_data;
  logic        o_rf_we;
  logic [4:0]  o_rf_addr;
  logic [31:0] o_rf_data;
  logic        o_dbg_ack;
  logic        o_pipe_stall;
  logic [15:0] o_dbg_write_count;

  reg_write_arbiter #(.LEN(32), .NB_ADDR(5), .STARVE_LIMIT(4), .NB_CNT(16)) dut (
    .i_clock              (i_clock),
    .i_reset              (i_reset),
    .i_wb_RegWrite        (i_wb_RegWrite),
    .i_wb_write_register  (i_wb_write_register),
    .i_wb_write_data      (i_wb_write_data),
    .i_dbg_req            (i_dbg_req),
    .i_dbg_write_register (i_dbg_write_register),
    .i_dbg_write_data     (i_dbg_write_data),
    .o_rf_we              (o_rf_we),
    .o_rf_addr            (o_rf_addr),
    .o_rf_data            (o_rf_data),
    .o_dbg_ack            (o_dbg_ack),
    .o_pipe_stall         (o_pipe_stall),
    .o_dbg_write_count    (o_dbg_write_count)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ack;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d,
                      input logic ack, input logic [15:0] c);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.ack = ack; e.cnt = c;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge i_clock);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    i_wb_RegWrite = we; i_wb_write_register = a; i_wb_write_data = d;
  endtask

  task automatic dbg(input logic req, input logic [4:0] a, input logic [31:0] d);
    i_dbg_req = req; i_dbg_write_register = a; i_dbg_write_data = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rf_we"}, 32'(o_rf_we), 32'd0);
    chk({tag, " rf_addr"}, 32'(o_rf_addr), 32'd0);
    chk({tag, " rf_data"}, o_rf_data, 32'd0);
    chk({tag, " dbg_ack"}, 32'(o_dbg_ack), 32'd0);
    chk({tag, " stall"}, 32'(o_pipe_stall), 32'd0);
    chk({tag, " count"}, 32'(o_dbg_write_count), 32'd0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clock);
      if (o_rf_we === 1'b1 || o_dbg_ack === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: we=%0b addr=%0d data=0x%0h ack=%0b, expected nothing at %0t",
                   o_rf_we, o_rf_addr, o_rf_data, o_dbg_ack, $time);
        end else begin
          e = q.pop_front();
          chk("mon rf_we", 32'(o_rf_we), 32'(e.we));
          chk("mon dbg_ack", 32'(o_dbg_ack), 32'(e.ack));
          if (e.we) begin
            chk("mon rf_addr", 32'(o_rf_addr), 32'(e.addr));
            chk("mon rf_data", o_rf_data, e.data);
          end
          if (e.ack) chk("mon dbg_count", 32'(o_dbg_write_count), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    i_reset = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    dbg(1'b0, 5'd0, 32'h0);
    cyc(); cyc();
    chk_all_zero("reset");
    i_reset = 1'b0;
    cyc();

    // Pipeline-only write, then hold of address/data when idle
    wb(1'b1, 5'd7, 32'h0000001C);
    push(1'b1, 5'd7, 32'h1C, 1'b0, 16'd0);
    cyc();
    wb(1'b0, 5'd0, 32'h0);
    cyc();
    chk("idle rf_we", 32'(o_rf_we), 32'd0);
    chk("hold rf_addr", 32'(o_rf_addr), 32'd7);
    chk("hold rf_data", o_rf_data, 32'h1C);

    // Debug write with the slot free, request held for 3 extra cycles
    dbg(1'b1, 5'd3, 32'hDEADBEEF);
    push(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 16'd1);
    cyc();
    cyc(); cyc(); cyc();
    dbg(1'b0, 5'd0, 32'h0);
    cyc(); cyc();
    chk("single_grant count", 32'(o_dbg_write_count), 32'd1);

    // Collision: write-back holds the slot for two cycles
    dbg(1'b1, 5'd3, 32'h00000033);
    wb(1'b1, 5'd5, 32'h00000055);
    push(1'b1, 5'd5, 32'h55, 1'b0, 16'd0);
    cyc();
    wb(1'b1, 5'd5, 32'h00000056);
    push(1'b1, 5'd5, 32'h56, 1'b0, 16'd0);
    cyc();
    wb(1'b0, 5'd0, 32'h0);
    push(1'b1, 5'd3, 32'h33, 1'b1, 16'd2);
    cyc();
    dbg(1'b0, 5'd0, 32'h0);
    cyc(); cyc();

    // Starvation: continuous write-back forces a stall, which never blocks write-back
    dbg(1'b1, 5'd9, 32'h00000099);
    for (int i = 0; i < 7; i++) begin
      wb(1'b1, 5'd4, 32'h40 + 32'(i));
      push(1'b1, 5'd4, 32'h40 + 32'(i), 1'b0, 16'd0);
      cyc();
      if (i == 3) chk("stall_early", 32'(o_pipe_stall), 32'd0);
    end
    chk("stall_raised", 32'(o_pipe_stall), 32'd1);
    wb(1'b0, 5'd0, 32'h0);
    push(1'b1, 5'd9, 32'h99, 1'b1, 16'd3);
    cyc();
    dbg(1'b0, 5'd0, 32'h0);
    cyc();
    chk("stall_released", 32'(o_pipe_stall), 32'd0);
    cyc();

    // Register 0: debug write acks and counts but does not write; write-back to r0 is dropped
    dbg(1'b1, 5'd0, 32'h00001234);
    push(1'b0, 5'd0, 32'h0, 1'b1, 16'd4);
    cyc();
    dbg(1'b0, 5'd0, 32'h0);
    wb(1'b1, 5'd0, 32'h00005678);
    cyc();
    wb(1'b0, 5'd0, 32'h0);
    cyc();
    chk("r0 count", 32'(o_dbg_write_count), 32'd4);

    // Request withdrawn in WAIT: no write, no ack, no stall
    dbg(1'b1, 5'd11, 32'h000000BB);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) i_dbg_req = 1'b0;
      wb(1'b1, 5'd6, 32'h60 + 32'(i));
      push(1'b1, 5'd6, 32'h60 + 32'(i), 1'b0, 16'd0);
      cyc();
    end
    wb(1'b0, 5'd0, 32'h0);
    cyc(); cyc();
    chk("withdraw stall", 32'(o_pipe_stall), 32'd0);
    chk("withdraw count", 32'(o_dbg_write_count), 32'd4);

    // Reset while stalled in WAIT abandons the request
    dbg(1'b1, 5'd10, 32'h000000AA);
    for (int i = 0; i < 8; i++) begin
      wb(1'b1, 5'd4, 32'h70 + 32'(i));
      push(1'b1, 5'd4, 32'h70 + 32'(i), 1'b0, 16'd0);
      cyc();
    end
    chk("pre_reset stall", 32'(o_pipe_stall), 32'd1);
    i_reset = 1'b1;
    i_dbg_req = 1'b0;
    cyc();
    chk_all_zero("mid_reset");
    i_reset = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 5; i++) cyc();
    chk("post_reset stall", 32'(o_pipe_stall), 32'd0);

    // First cycle after reset behaves as IDLE
    dbg(1'b1, 5'd12, 32'h00C0FFEE);
    push(1'b1, 5'd12, 32'h00C0FFEE, 1'b1, 16'd1);
    cyc();
    dbg(1'b0, 5'd0, 32'h0);
    cyc(); cyc();

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameters SHALL be: LEN, default 32, data width; NB_ADDR, default 5, register address width; STARVE_LIMIT, default 4, number of WAIT cycles before a stall is forced; NB_CNT, default 16, debug write counter width.
REQ-002 i_clock  input  1  single clock; all state updates on the rising edge.
REQ-003 i_reset  input  1  reset, synchronous and active-high.
REQ-004 i_wb_RegWrite  input  1  write-back stage write enable; the highest-priority source.
REQ-005 i_wb_write_register  input  NB_ADDR  write-back destination register.
REQ-006 i_wb_write_data  input  LEN  write-back data.
REQ-007 i_dbg_req  input  1  debug unit write request; held high until acknowledged.
REQ-008 i_dbg_write_register  input  NB_ADDR  debug destination; stable while i_dbg_req is high.
REQ-009 i_dbg_write_data  input  LEN  debug data; stable while i_dbg_req is high.
REQ-010 o_rf_we  output  1  registered register-file write enable.
REQ-011 o_rf_addr  output  NB_ADDR  registered register-file write address.
REQ-012 o_rf_data  output  LEN  registered register-file write data.
REQ-013 o_dbg_ack  output  1  one-cycle pulse marking the debug write as granted.
REQ-014 o_pipe_stall  output  1  registered request that the pipeline freeze write-back.
REQ-015 o_dbg_write_count  output  NB_CNT  number of debug writes committed.

Function
REQ-016 The pipeline slot SHALL be free in a cycle when i_wb_RegWrite==0 or i_wb_write_register==0.
REQ-017 When i_wb_RegWrite==1 and i_wb_write_register!=0, the block SHALL register the pipeline write onto o_rf_we/o_rf_addr/o_rf_data the next cycle, giving 1-cycle latency, regardless of FSM state.
REQ-018 Writes to register 0 from either source SHALL produce o_rf_we=0.
REQ-019 The FSM SHALL have the states IDLE, WAIT and RELEASE.
REQ-020 In IDLE with i_dbg_req=1:
- if the pipeline slot is free: grant in that cycle and go to RELEASE;
- otherwise: go to WAIT.
REQ-021 In WAIT, the block SHALL grant in the first cycle where the pipeline slot is free and then go to RELEASE.
REQ-022 A grant SHALL:
- register the debug write on o_rf_* the next cycle;
- pulse o_dbg_ack for exactly one cycle, aligned with that o_rf_we;
- increment o_dbg_write_count, wrapping at 2^NB_CNT; writes to register 0 also count.
REQ-023 In RELEASE, the FSM SHALL stay until i_dbg_req==0 and then go to IDLE, so that one request produces exactly one write.
REQ-024 The starvation counter SHALL increment on each WAIT cycle without a grant, saturate at STARVE_LIMIT, and clear on leaving WAIT.
REQ-025 o_pipe_stall SHALL assert the cycle after the counter reaches STARVE_LIMIT and stay high until the cycle after the grant.
REQ-026 Inside the block, o_pipe_stall SHALL NOT block a pipeline write; the pipeline always keeps priority.
REQ-027 When no write is selected, o_rf_we SHALL be 0; o_rf_addr and o_rf_data SHALL hold their last values.
REQ-028 If i_dbg_req drops in WAIT before a grant, the FSM SHALL return to IDLE with no write and no ack, and o_pipe_stall SHALL deassert the next cycle.

Reset
REQ-029 With i_reset=1 at a clock edge, the block SHALL set:
- the FSM to IDLE;
- o_rf_we=0, o_rf_addr=0, o_rf_data=0;
- o_dbg_ack=0, o_pipe_stall=0, o_dbg_write_count=0;
- the starvation counter to 0.
REQ-030 A reset asserted mid-handshake (WAIT or RELEASE) SHALL abandon the pending debug write; no ack is issued afterwards for that request.
REQ-031 In the cycle after reset deasserts, the block SHALL behave as in IDLE.

Verification
REQ-032 Pipeline-only write: wb RegWrite=1, reg=7, data=0x0000001C -> next cycle o_rf_we=1, o_rf_addr=7, o_rf_data=0x1C, o_dbg_ack=0.
REQ-033 Debug write with the pipeline slot free: dbg_req=1, reg=3, data=0xDEADBEEF, wb RegWrite=0 -> next cycle o_rf_we=1, o_rf_addr=3, o_rf_data=0xDEADBEEF, o_dbg_ack=1, count=1; holding dbg_req high for 3 more cycles -> no further ack or write.
REQ-034 Collision: dbg_req=1 (reg 3) while wb writes reg 5 for 2 cycles -> reg 5 is written twice, then reg 3 is written with ack in the cycle after the slot frees.
REQ-035 Starvation: wb writes continuously, dbg_req=1, STARVE_LIMIT=4 -> o_pipe_stall=1 after 4 WAIT cycles; dropping wb RegWrite -> debug write plus ack, and o_pipe_stall=0 the following cycle.
REQ-036 Register-0 and reset checks:
- debug write to reg 0 -> o_dbg_ack=1, o_rf_we=0, count increments;
- i_reset=1 while in WAIT with o_pipe_stall=1 -> all outputs 0 next cycle, FSM in IDLE, no ack later.
